pkt_fifo: RTL

PKT_FIFO -- requirements
Module: pkt_fifo

---
 rtl/fifo_pkg.sv | 9 +
 rtl/pkt_fifo_ram.sv | 32 +++
 rtl/pkt_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg -- defaults shared by the FIFO family.
//   DEF_DATA_WIDTH : default payload width in bits
//   DEF_ADDR_WIDTH : default log2 of the storage depth
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

endpackage : fifo_pkg

// File: rtl/pkt_fifo_ram.sv
// pkt_fifo_ram -- storage array for pkt_fifo, distributed-RAM style.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word ({last, payload})
//   raddr : read address (asynchronous read)
//   rdata : word at raddr, combinational
module pkt_fifo_ram #(
    parameter int WIDTH      = 9,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: storage has no reset; emptiness is defined by the pointers, and a
    // reset port would keep the array from mapping onto LUT RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : pkt_fifo_ram

// File: rtl/pkt_fifo.sv
// pkt_fifo -- packet FIFO with speculative write and commit-on-last.
// Words of a packet become readable only when the word carrying wr_last is
// written; wr_drop rolls the speculative pointer back to the last commit.
//   clk, rst              : clock, asynchronous active-high reset
//   din, wr_en, wr_last   : write word, strobe, end-of-packet (commits)
//   wr_drop               : discard the uncommitted packet in progress
//   full, almost_full     : space flags (speculative words included)
//   wr_count              : words held, speculative included
//   dout, dout_last       : read word and its last flag
//   rd_en                 : read strobe
//   empty, almost_empty   : committed-data flags
//   rd_count              : committed words readable
//   pkt_count             : complete packets held
//   overflow, underflow   : one-cycle pulses for rejected write / read
module pkt_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FWFT_EN    = 1,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  wr_last,
    input  logic                  wr_drop,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] wptr_c;
    logic [ADDR_WIDTH:0] wptr_s;
    logic [ADDR_WIDTH:0] wptr_s_inc;

    logic [DATA_WIDTH:0] rd_word;
    logic [DATA_WIDTH:0] last_rd_q;

    logic write_ok;
    logic read_ok;
    logic commit;
    logic pkt_out;

    assign empty = (rptr == wptr_c);
    assign full  = (wptr_s[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr_s[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    assign wr_count = wptr_s - rptr;
    assign rd_count = wptr_c - rptr;

    assign almost_full  = (int'(wr_count) >= AF_THRESH);
    assign almost_empty = (int'(rd_count) <= AE_THRESH);

    // A drop in the same cycle wins over the write.
    assign write_ok   = wr_en & ~full & ~wr_drop;
    assign read_ok    = rd_en & ~empty;
    assign commit     = write_ok & wr_last;
    assign pkt_out    = read_ok & rd_word[DATA_WIDTH];
    assign wptr_s_inc = wptr_s + PTR_ONE;

    pkt_fifo_ram #(
        .WIDTH      (DATA_WIDTH + 1),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (write_ok),
        .waddr (wptr_s[ADDR_WIDTH-1:0]),
        .wdata ({wr_last, din}),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (rd_word)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, which is what makes simultaneous
    // read/write at full or empty resolve on the old state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr      <= '0;
            wptr_c    <= '0;
            wptr_s    <= '0;
            pkt_count <= '0;
            last_rd_q <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_drop) begin
                wptr_s <= wptr_c;
            end else if (write_ok) begin
                wptr_s <= wptr_s_inc;
                if (wr_last) begin
                    wptr_c <= wptr_s_inc;
                end
            end

            if (read_ok) begin
                rptr      <= rptr + PTR_ONE;
                last_rd_q <= rd_word;
            end

            // Commit and last-word read in one cycle cancel out.
            case ({commit, pkt_out})
                2'b10:   pkt_count <= pkt_count + PTR_ONE;
                2'b01:   pkt_count <= pkt_count - PTR_ONE;
                default: pkt_count <= pkt_count;
            endcase

            overflow  <= wr_en & full & ~wr_drop;
            underflow <= rd_en & empty;
        end
    end

    // FWFT shows the head word while data is present; otherwise (and always
    // in registered mode) the output is the last word actually read.
    assign {dout_last, dout} = ((FWFT_EN != 0) && !empty) ? rd_word : last_rd_q;

endmodule : pkt_fifo
